// File: rtl/qbus_master.sv
// Bus-cycle sequencer for the 1801VM1 multiplexed active-low bus: turns one host
// request into an address/data cycle with reply synchronization and a reply-wait timeout.
module qbus_master #(
  parameter int ADDR_SETUP  = 1,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic        byte_op,
  input  logic [15:0] addr,
  input  logic [15:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [15:0] rdata,
  inout  wire  [15:0] ad_n,
  output logic [1:0]  sel_n,
  output logic        sync_n,
  output logic        din_n,
  output logic        dout_n,
  output logic        wtbt_n,
  input  logic        rply_n
);

  localparam int SW = (ADDR_SETUP > 1) ? $clog2(ADDR_SETUP) : 1;
  localparam int TW = $clog2(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE, S_ODD, S_ADDR, S_SYNC, S_WAIT, S_RELEASE
  } state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] rply_sync_q, rply_sync_d;
  logic [SW-1:0]          setup_q, setup_d;
  logic [TW-1:0]          timer_q, timer_d;
  logic                   busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic                   sync_n_q, sync_n_d, din_n_q, din_n_d;
  logic                   dout_n_q, dout_n_d, wtbt_n_q, wtbt_n_d;
  logic                   ad_oe_q, ad_oe_d;
  logic [15:0]            rdata_q, rdata_d;
  logic [15:0]            ad_out_q, ad_out_d, wdata_q, wdata_d;
  logic                   we_q, we_d, byte_q, byte_d;
  logic                   rply_s, accept, odd_word, setup_end, timeout;

  assign rply_s    = rply_sync_q[SYNC_STAGES-1];
  assign accept    = (state_q == S_IDLE) && req && !done_q;
  assign odd_word  = !byte_op && addr[0];
  assign setup_end = (setup_q == SW'(ADDR_SETUP - 1));
  assign timeout   = (timer_q == TW'(TIMEOUT - 1));

  assign ad_n   = ad_oe_q ? ad_out_q : 16'bz;
  assign sel_n  = 2'b11;
  assign busy   = busy_q;
  assign done   = done_q;
  assign err    = err_q;
  assign rdata  = rdata_q;
  assign sync_n = sync_n_q;
  assign din_n  = din_n_q;
  assign dout_n = dout_n_q;
  assign wtbt_n = wtbt_n_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      rply_sync_q <= '1;
      setup_q     <= '0;
      timer_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      sync_n_q    <= 1'b1;
      din_n_q     <= 1'b1;
      dout_n_q    <= 1'b1;
      wtbt_n_q    <= 1'b1;
      ad_oe_q     <= 1'b0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      rply_sync_q <= rply_sync_d;
      setup_q     <= setup_d;
      timer_q     <= timer_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      sync_n_q    <= sync_n_d;
      din_n_q     <= din_n_d;
      dout_n_q    <= dout_n_d;
      wtbt_n_q    <= wtbt_n_d;
      ad_oe_q     <= ad_oe_d;
      rdata_q     <= rdata_d;
    end
  end

  // Request payload and bus data need no reset: they are qualified by state/ad_oe.
  always_ff @(posedge clk) begin
    we_q     <= we_d;
    byte_q   <= byte_d;
    wdata_q  <= wdata_d;
    ad_out_q <= ad_out_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (accept) state_d = odd_word ? S_ODD : S_ADDR;
      S_ODD:     state_d = S_IDLE;
      S_ADDR:    if (setup_end) state_d = S_SYNC;
      S_SYNC:    state_d = S_WAIT;
      S_WAIT:    if (!rply_s) state_d = S_RELEASE;
                 else if (timeout) state_d = S_IDLE;
      S_RELEASE: if (rply_s || timeout) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    rply_sync_d = SYNC_STAGES'({rply_sync_q, rply_n});
    setup_d  = setup_q;
    timer_d  = timer_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    sync_n_d = sync_n_q;
    din_n_d  = din_n_q;
    dout_n_d = dout_n_q;
    wtbt_n_d = wtbt_n_q;
    ad_oe_d  = ad_oe_q;
    ad_out_d = ad_out_q;
    rdata_d  = rdata_q;
    we_d     = we_q;
    byte_d   = byte_q;
    wdata_d  = wdata_q;
    case (state_q)
      S_IDLE: if (accept) begin
        we_d    = we;
        byte_d  = byte_op;
        wdata_d = wdata;
        busy_d  = 1'b1;
        setup_d = '0;
        if (!odd_word) begin
          ad_out_d = ~addr;
          ad_oe_d  = 1'b1;
          wtbt_n_d = ~we;
        end
      end
      S_ODD: begin
        done_d = 1'b1;
        err_d  = 1'b1;
        busy_d = 1'b0;
      end
      S_ADDR: begin
        if (setup_end) sync_n_d = 1'b0;
        else           setup_d  = setup_q + SW'(1);
      end
      S_SYNC: begin
        timer_d = '0;
        if (we_q) begin
          ad_out_d = byte_q ? ~{wdata_q[7:0], wdata_q[7:0]} : ~wdata_q;
          wtbt_n_d = ~byte_q;
          dout_n_d = 1'b0;
        end else begin
          ad_oe_d = 1'b0;
          din_n_d = 1'b0;
        end
      end
      S_WAIT, S_RELEASE: begin
        timer_d = timer_q + TW'(1);
        if (state_q == S_WAIT && !rply_s) begin
          if (!we_q) rdata_d = ~ad_n;
          din_n_d  = 1'b1;
          dout_n_d = 1'b1;
        end else if (state_q == S_RELEASE && rply_s) begin
          sync_n_d = 1'b1;
          wtbt_n_d = 1'b1;
          ad_oe_d  = 1'b0;
          done_d   = 1'b1;
          busy_d   = 1'b0;
        end else if (timeout) begin
          // Slave never answered (or never let go): abandon the cycle cleanly.
          sync_n_d = 1'b1;
          din_n_d  = 1'b1;
          dout_n_d = 1'b1;
          wtbt_n_d = 1'b1;
          ad_oe_d  = 1'b0;
          done_d   = 1'b1;
          err_d    = 1'b1;
          busy_d   = 1'b0;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_qbus_master.sv
// Bench for qbus_master: behavioural bus memory slave on the pins plus a word-array
// reference model of memory contents, host-side results and cycle latencies.
module tb_qbus_master;

  localparam int ADDR_SETUP  = 1;
  localparam int SYNC_STAGES = 2;
  localparam int TIMEOUT     = 16;
  localparam int LAT_OK      = ADDR_SETUP + 2 * SYNC_STAGES + 3;
  localparam int LAT_TO      = ADDR_SETUP + 1 + TIMEOUT;

  logic        clk = 0, rst = 1, req = 0, we = 0, byte_op = 0;
  logic [15:0] addr = 0, wdata = 0;
  logic        busy, done, err, sync_n, din_n, dout_n, wtbt_n;
  logic [15:0] rdata;
  logic [1:0]  sel_n;
  logic        rply_n = 1;
  wire  [15:0] ad_n;

  logic        mem_drive = 0;
  logic [15:0] mem_rd = 0;
  assign ad_n = mem_drive ? mem_rd : 16'bz;

  qbus_master #(.ADDR_SETUP(ADDR_SETUP), .SYNC_STAGES(SYNC_STAGES), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .byte_op(byte_op), .addr(addr), .wdata(wdata),
    .busy(busy), .done(done), .err(err), .rdata(rdata), .ad_n(ad_n), .sel_n(sel_n),
    .sync_n(sync_n), .din_n(din_n), .dout_n(dout_n), .wtbt_n(wtbt_n), .rply_n(rply_n)
  );

  always #5 clk = ~clk;

  int          checks = 0, fails = 0;
  logic [15:0] mem     [0:32767];
  logic [15:0] ref_mem [0:32767];
  logic [15:0] exp_rdata = 0;
  logic        kill_sel = 0;   // stand-in for pulling sel_n out of memory space
  logic [15:0] slv_addr = 0;
  logic        slv_wrote = 0;
  logic        sync_seen = 0, sync_prev = 1, wtbt_at_sync = 1, wtbt_at_dout = 1;
  int          sync_cnt = 0;

  // Zero-wait memory slave: latches the address while sync_n is high, replies while a strobe is low.
  always @(negedge clk) begin
    logic        sel_ok;
    logic [15:0] d;
    sel_ok = ((kill_sel ? 2'b00 : sel_n) == 2'b11);
    if (sync_n) begin
      slv_addr  = ~ad_n;
      slv_wrote = 0;
    end
    if (sel_ok && !sync_n && !din_n) begin
      mem_rd    = ~mem[slv_addr[15:1]];
      mem_drive = 1;
      rply_n    = 0;
    end else if (sel_ok && !sync_n && !dout_n) begin
      if (!slv_wrote) begin
        d = ~ad_n;
        if (wtbt_n)           mem[slv_addr[15:1]]       = d;
        else if (slv_addr[0]) mem[slv_addr[15:1]][15:8] = d[15:8];
        else                  mem[slv_addr[15:1]][7:0]  = d[7:0];
        slv_wrote = 1;
      end
      mem_drive = 0;
      rply_n    = 0;
    end else begin
      mem_drive = 0;
      rply_n    = 1;
    end
  end

  always @(negedge clk) begin
    checks++;
    if (!din_n && !dout_n) begin
      fails++;
      $display("FAIL strobe_overlap: din_n=%b dout_n=%b, required never both 0", din_n, dout_n);
    end
    if (!sync_n && !sync_seen) wtbt_at_sync = wtbt_n;
    if (!sync_n) sync_seen = 1;
    if (!dout_n) wtbt_at_dout = wtbt_n;
    if (!sync_n && sync_prev) sync_cnt++;
    sync_prev = sync_n;
  end

  task automatic do_op(input logic w, input logic b, input logic [15:0] a, input logic [15:0] d,
                       output logic [15:0] rd, output logic e, output int lat);
    @(negedge clk);
    while (busy || done) @(negedge clk);
    sync_seen = 0;
    req = 1; we = w; byte_op = b; addr = a; wdata = d;
    @(posedge clk);
    @(negedge clk);
    req = 0;
    lat = 0;
    e = 0;
    rd = 0;
    while (lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
      if (done) break;
    end
    if (!done) begin
      checks++; fails++;
      $display("FAIL op_timeout: no done within %0d cycles for addr %h", lat, a);
      lat = -1;
    end
    rd = rdata;
    e  = err;
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if ({sync_n, din_n, dout_n, wtbt_n} !== 4'b1111) begin fails++;
      $display("FAIL reset_strobes: got %b, required 1111", {sync_n, din_n, dout_n, wtbt_n}); end
    checks++; if ({busy, done, err} !== 3'b000) begin fails++;
      $display("FAIL reset_status: busy/done/err got %b, required 000", {busy, done, err}); end
    checks++; if (rdata !== 16'h0000) begin fails++;
      $display("FAIL reset_rdata: got %h, required 0000", rdata); end
    checks++; if (sel_n !== 2'b11) begin fails++;
      $display("FAIL sel_n: got %b, required 11", sel_n); end
    @(negedge clk);
    rst = 0;
  endtask

  task automatic test_read();
    logic [15:0] rd; logic e; int lat;
    mem[16'h0100] = 16'hBEEF; ref_mem[16'h0100] = 16'hBEEF;
    do_op(0, 0, 16'h0200, 16'h0, rd, e, lat);
    exp_rdata = ref_mem[16'h0100];
    checks++; if (rd !== exp_rdata) begin fails++; $display("FAIL read_data: got %h, required %h", rd, exp_rdata); end
    checks++; if (e !== 1'b0) begin fails++; $display("FAIL read_err: got %b, required 0", e); end
    checks++; if (lat != LAT_OK) begin fails++; $display("FAIL read_latency: got %0d, required %0d", lat, LAT_OK); end
  endtask

  task automatic test_word_write();
    logic [15:0] rd; logic e; int lat;
    do_op(1, 0, 16'h0300, 16'h1234, rd, e, lat);
    ref_mem[16'h0180] = 16'h1234;
    checks++; if (e !== 1'b0 || lat != LAT_OK) begin fails++;
      $display("FAIL wwrite_done: err=%b lat=%0d, required err=0 lat=%0d", e, lat, LAT_OK); end
    checks++; if (wtbt_at_sync !== 1'b0) begin fails++;
      $display("FAIL wwrite_wtbt_addr: got %b, required 0", wtbt_at_sync); end
    checks++; if (wtbt_at_dout !== 1'b1) begin fails++;
      $display("FAIL wwrite_wtbt_data: got %b, required 1", wtbt_at_dout); end
    do_op(0, 0, 16'h0300, 16'h0, rd, e, lat);
    exp_rdata = ref_mem[16'h0180];
    checks++; if (rd !== exp_rdata) begin fails++; $display("FAIL wwrite_readback: got %h, required %h", rd, exp_rdata); end
  endtask

  task automatic test_byte_write();
    logic [15:0] rd; logic e; int lat;
    do_op(1, 1, 16'h0301, 16'h55AB, rd, e, lat);
    checks++; if (wtbt_at_dout !== 1'b0) begin fails++;
      $display("FAIL bwrite_wtbt_data: got %b, required 0", wtbt_at_dout); end
    do_op(0, 0, 16'h0300, 16'h0, rd, e, lat);
    checks++; if (rd !== 16'hAB34) begin fails++; $display("FAIL bwrite_hi: got %h, required AB34", rd); end
    do_op(1, 1, 16'h0300, 16'h77CD, rd, e, lat);
    do_op(0, 0, 16'h0300, 16'h0, rd, e, lat);
    checks++; if (rd !== 16'hABCD) begin fails++; $display("FAIL bwrite_lo: got %h, required ABCD", rd); end
    ref_mem[16'h0180] = 16'hABCD;
    exp_rdata = 16'hABCD;
  endtask

  task automatic test_odd_addr();
    logic [15:0] rd; logic e; int lat;
    do_op(0, 0, 16'h0201, 16'h0, rd, e, lat);
    checks++; if (e !== 1'b1 || lat != 1) begin fails++;
      $display("FAIL odd_addr: err=%b lat=%0d, required err=1 lat=1", e, lat); end
    checks++; if (sync_seen !== 1'b0) begin fails++; $display("FAIL odd_sync: sync_n asserted, required to stay 1"); end
    checks++; if (rd !== exp_rdata) begin fails++; $display("FAIL odd_rdata: got %h, required %h", rd, exp_rdata); end
  endtask

  task automatic test_timeout();
    logic [15:0] rd; logic e; int lat;
    kill_sel = 1;
    do_op(0, 0, 16'h0200, 16'h0, rd, e, lat);
    checks++; if (e !== 1'b1 || lat != LAT_TO) begin fails++;
      $display("FAIL timeout: err=%b lat=%0d, required err=1 lat=%0d", e, lat, LAT_TO); end
    checks++; if (rd !== exp_rdata) begin fails++; $display("FAIL timeout_rdata: got %h, required %h", rd, exp_rdata); end
    checks++; if ({sync_n, din_n, dout_n, wtbt_n, busy} !== 5'b11110) begin fails++;
      $display("FAIL timeout_idle: strobes/busy got %b, required 11110", {sync_n, din_n, dout_n, wtbt_n, busy}); end
    kill_sel = 0;
    do_op(0, 0, 16'h0200, 16'h0, rd, e, lat);
    exp_rdata = ref_mem[16'h0100];
    checks++; if (rd !== exp_rdata || e !== 1'b0) begin fails++;
      $display("FAIL post_timeout_read: got %h err=%b, required %h err=0", rd, e, exp_rdata); end
  endtask

  task automatic test_rst_and_busy_req();
    int n, busy_hits;
    kill_sel = 1;
    @(negedge clk);
    while (busy || done) @(negedge clk);
    req = 1; we = 0; byte_op = 0; addr = 16'h0200;
    @(posedge clk);
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1; req = 0;
    @(posedge clk);
    #1;
    exp_rdata = 16'h0000;
    checks++; if ({sync_n, din_n, dout_n, wtbt_n} !== 4'b1111) begin fails++;
      $display("FAIL midwait_rst_strobes: got %b, required 1111", {sync_n, din_n, dout_n, wtbt_n}); end
    checks++; if ({busy, done, err} !== 3'b000 || rdata !== exp_rdata) begin fails++;
      $display("FAIL midwait_rst_status: busy/done/err %b rdata %h, required 000 0000", {busy, done, err}, rdata); end
    @(negedge clk);
    rst = 0; kill_sel = 0;
    @(negedge clk);
    sync_cnt = 0;
    req = 1; we = 0; byte_op = 0; addr = 16'h0300;
    @(posedge clk);
    n = 0;
    while (n < 200) begin
      @(posedge clk); #1; n++;
      if (done) break;
    end
    @(negedge clk);
    req = 0;
    exp_rdata = ref_mem[16'h0180];
    checks++; if (n != LAT_OK || rdata !== exp_rdata) begin fails++;
      $display("FAIL held_req_cycle: lat=%0d rdata=%h, required lat=%0d rdata=%h", n, rdata, LAT_OK, exp_rdata); end
    busy_hits = 0;
    repeat (12) begin @(posedge clk); #1; if (busy) busy_hits++; end
    checks++; if (sync_cnt != 1 || busy_hits != 0) begin fails++;
      $display("FAIL held_req_extra: cycles=%0d busy_after=%0d, required 1 and 0", sync_cnt, busy_hits); end
  endtask

  task automatic test_random();
    logic [15:0] rd, a, d, cur; logic e, w, b, e_exp; int lat, lat_exp;
    for (int i = 16'h0200; i < 16'h0210; i++) begin
      mem[i] = 16'($urandom); ref_mem[i] = mem[i];
    end
    for (int k = 0; k < 40; k++) begin
      w = 1'($urandom); b = 1'($urandom);
      a = 16'h0400 + 16'($urandom_range(0, 31));
      d = 16'($urandom);
      e_exp   = !b && a[0];
      lat_exp = e_exp ? 1 : LAT_OK;
      do_op(w, b, a, d, rd, e, lat);
      if (!e_exp) begin
        cur = ref_mem[a[15:1]];
        if (w && !b)      cur = d;
        else if (w && a[0]) cur = {d[7:0], cur[7:0]};
        else if (w)       cur = {cur[15:8], d[7:0]};
        ref_mem[a[15:1]] = cur;
        if (!w) exp_rdata = cur;
      end
      checks++; if (e !== e_exp || lat != lat_exp) begin fails++;
        $display("FAIL rand_%0d_status: err=%b lat=%0d, required err=%b lat=%0d", k, e, lat, e_exp, lat_exp); end
      checks++; if (rd !== exp_rdata) begin fails++;
        $display("FAIL rand_%0d_rdata: got %h, required %h (addr %h)", k, rd, exp_rdata, a); end
    end
  endtask

  initial begin
    for (int i = 0; i < 32768; i++) begin mem[i] = 16'h0; ref_mem[i] = 16'h0; end
    test_reset();
    test_read();
    test_word_write();
    test_byte_write();
    test_odd_addr();
    test_timeout();
    test_rst_and_busy_req();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
